// File: rtl/newton_sub.sv
// Newton-step subtract D = C - P for the inverse-sqrt datapath.
// Three-stage unpack / align-subtract / normalise pipeline, one result per clock.
module newton_sub #(
  parameter logic [31:0] CONST    = 32'h3FC00000,
  parameter bit          HALVE_IN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_operand,
  input  logic [31:0] in_side,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_side
);

  localparam logic [7:0]  CE = CONST[30:23];
  localparam logic [25:0] CM = {1'b1, CONST[22:0], 2'b00};

  logic        w_en;

  logic [7:0]  w_eraw;
  logic [7:0]  w_ep;
  logic [25:0] w_mp;
  logic        w_pzero;
  logic        w_pgt;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [25:0] w_ma;
  logic [25:0] w_mb;

  logic        r1_v;
  logic [7:0]  r1_d;
  logic [7:0]  r1_ea;
  logic [25:0] r1_ma;
  logic [25:0] r1_mb;
  logic        r1_sign;
  logic [31:0] r1_side;

  logic [25:0] w_bal;

  logic        r2_v;
  logic [25:0] r2_diff;
  logic [7:0]  r2_ea;
  logic        r2_sign;
  logic [31:0] r2_side;

  logic [4:0]  w_lz;
  logic        w_found;
  logic [25:0] w_norm;
  logic [7:0]  w_e;
  logic [31:0] w_res;

  logic        r3_v;
  logic [31:0] r3_res;
  logic [31:0] r3_side;

  // A single enable moves every stage, so a full stall freezes bubbles too
  assign w_en       = !r3_v || out_ready;
  assign in_ready   = w_en;
  assign out_valid  = r3_v;
  assign out_result = r3_res;
  assign out_side   = r3_side;

  assign w_eraw  = in_operand[30:23];
  assign w_pzero = (w_eraw == 8'd0) ||
                   (HALVE_IN && (w_eraw == 8'd1));
  assign w_ep    = w_eraw - {7'd0, HALVE_IN};
  assign w_mp    = {1'b1, in_operand[22:0], 2'b00};
  assign w_pgt   = !w_pzero &&
                   ({w_ep, w_mp} > {CE, CM});

  always_comb begin
    w_ea = CE;
    w_ma = CM;
    w_eb = w_ep;
    w_mb = w_mp;
    if (w_pzero) begin
      w_eb = CE;
      w_mb = '0;
    end else if (w_pgt) begin
      w_ea = w_ep;
      w_ma = w_mp;
      w_eb = CE;
      w_mb = CM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v    <= 1'b0;
      r1_d    <= '0;
      r1_ea   <= '0;
      r1_ma   <= '0;
      r1_mb   <= '0;
      r1_sign <= 1'b0;
      r1_side <= '0;
    end else if (w_en) begin
      r1_v    <= in_valid;
      r1_d    <= w_ea - w_eb;
      r1_ea   <= w_ea;
      r1_ma   <= w_ma;
      r1_mb   <= w_mb;
      r1_sign <= w_pgt;
      r1_side <= in_side;
    end
  end

  assign w_bal = (r1_d >= 8'd26) ? 26'd0 : (r1_mb >> r1_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_diff <= '0;
      r2_ea   <= '0;
      r2_sign <= 1'b0;
      r2_side <= '0;
    end else if (w_en) begin
      r2_v    <= r1_v;
      r2_diff <= r1_ma - w_bal;
      r2_ea   <= r1_ea;
      r2_sign <= r1_sign;
      r2_side <= r1_side;
    end
  end

  always_comb begin
    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!w_found && r2_diff[i]) begin
        w_lz    = 5'(25 - i);
        w_found = 1'b1;
      end
    end
  end

  assign w_norm = r2_diff << w_lz;
  assign w_e    = r2_ea - {3'd0, w_lz};

  always_comb begin
    w_res = {r2_sign, w_e, w_norm[24:2]};
    if ((r2_diff == 26'd0) || ({3'd0, w_lz} >= r2_ea))
      w_res = 32'h00000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v    <= 1'b0;
      r3_res  <= '0;
      r3_side <= '0;
    end else if (w_en) begin
      r3_v    <= r2_v;
      r3_res  <= w_res;
      r3_side <= r2_side;
    end
  end

endmodule
